// File: rtl/network_lock_monitor_pkg.sv
// Shared definitions for the ADPLL network lock monitor: default array geometry,
// FSM state encoding and small elaboration-time helpers.
package network_lock_monitor_pkg;

  localparam int DEF_NUM_NODES = 4;
  localparam int DEF_ERR_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_EVAL  = 2'd3
  } state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/network_lock_monitor_edge_counter.sv
// Rising-edge detector feeding a saturating counter with synchronous clear and enable.
// count_o is the value including this cycle's edge, so a snapshot taken on clear sees it.
module edge_counter #(
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 prev_q, prev_d;
  logic                 edge_det;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    prev_d   = sig_i;
    edge_det = sig_i & ~prev_q;
    count_o  = cnt_q;
    if (en_i && edge_det && (cnt_q != CNT_MAX)) begin
      count_o = cnt_q + CNT_ONE;
    end
    cnt_d = clr_i ? '0 : count_o;
  end

  // Previous sample resets high so a line already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/network_lock_monitor.sv
// Frequency-error observer for the ADPLL array: counts each node's div8 edges over a
// gate window of reference edges, applies lock hysteresis and reports a selected error.
module network_lock_monitor
  import network_lock_monitor_pkg::*;
#(
  parameter int NUM_NODES      = DEF_NUM_NODES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int WINDOW_EDGES   = 256,
  parameter int TOL            = 2,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2,
  parameter int ERR_WIDTH      = DEF_ERR_WIDTH
) (
  input  logic                                fpga_clk_i,
  input  logic                                reset_i,
  input  logic                                enable_i,
  input  logic                                ref_i,
  input  logic [NUM_NODES-1:0]                gen_i,
  input  logic [sel_width(NUM_NODES)-1:0]     sel_i,
  output logic [NUM_NODES-1:0]                lock_o,
  output logic                                all_locked_o,
  output logic signed [ERR_WIDTH-1:0]         err_o,
  output logic                                err_valid_o,
  output state_e                              dbg_state_o
);

  localparam int HYST_W = $clog2(max_int(LOCK_WINDOWS, UNLOCK_WINDOWS) + 1);
  localparam logic [HYST_W-1:0]           LOCK_N   = HYST_W'(LOCK_WINDOWS);
  localparam logic [HYST_W-1:0]           UNLOCK_N = HYST_W'(UNLOCK_WINDOWS);
  localparam logic [HYST_W-1:0]           HYST_ONE = HYST_W'(1);
  localparam logic [CNT_WIDTH-1:0]        WIN_N    = CNT_WIDTH'(WINDOW_EDGES);
  localparam logic signed [CNT_WIDTH:0]   TOL_P    = (CNT_WIDTH+1)'(TOL);
  localparam logic signed [CNT_WIDTH:0]   TOL_M    = -TOL_P;
  localparam int                          ERR_MAX  = (2 ** (ERR_WIDTH - 1)) - 1;
  localparam int                          ERR_MIN  = -(2 ** (ERR_WIDTH - 1));

  state_e                              state_q, state_d;
  logic                                cnt_en, cnt_clr, closing;
  logic [CNT_WIDTH-1:0]                ref_next;
  logic [NUM_NODES-1:0][CNT_WIDTH-1:0] gen_next;
  logic [NUM_NODES-1:0][CNT_WIDTH-1:0] snap_q, snap_d;
  logic [NUM_NODES-1:0][CNT_WIDTH:0]   diff;
  logic [NUM_NODES-1:0]                in_tol;
  logic [NUM_NODES-1:0][HYST_W-1:0]    good_q, good_d, bad_q, bad_d;
  logic [NUM_NODES-1:0]                lock_q, lock_d;
  logic                                all_locked_q, all_locked_d;
  logic                                err_valid_q, err_valid_d;
  logic signed [ERR_WIDTH-1:0]         err_q, err_d;
  int                                  err_full;

  // Counters are held clear outside a window; in ARM they still report an incoming edge
  // through count_o, which is how the arming reference edge is spotted.
  always_comb begin
    closing = (state_q == ST_COUNT) && (ref_next == WIN_N);
    cnt_en  = (state_q != ST_IDLE);
    cnt_clr = !enable_i || (state_q == ST_IDLE) || (state_q == ST_ARM) || closing;
  end

  edge_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ref_cnt (
    .clk     (fpga_clk_i),
    .rst     (reset_i),
    .sig_i   (ref_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (ref_next)
  );

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
    edge_counter #(.CNT_WIDTH(CNT_WIDTH)) u_gen_cnt (
      .clk     (fpga_clk_i),
      .rst     (reset_i),
      .sig_i   (gen_i[n]),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (gen_next[n])
    );
    assign diff[n]   = {1'b0, snap_q[n]} - {1'b0, WIN_N};
    assign in_tol[n] = ($signed(diff[n]) >= TOL_M) && ($signed(diff[n]) <= TOL_P);
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    unique case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_ARM;
      ST_ARM:   if (ref_next != '0) state_d = ST_COUNT;
      ST_COUNT: begin
        if (closing) begin
          snap_d  = gen_next;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL:  state_d = ST_COUNT;
      default:  state_d = ST_IDLE;
    endcase
    if (!enable_i) state_d = ST_IDLE;
  end

  always_comb begin
    good_d      = good_q;
    bad_d       = bad_q;
    lock_d      = lock_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    err_full    = 0;
    if (state_q == ST_EVAL) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        if (in_tol[n]) begin
          bad_d[n] = '0;
          if (good_q[n] != LOCK_N) good_d[n] = good_q[n] + HYST_ONE;
          if (good_d[n] == LOCK_N) lock_d[n] = 1'b1;
        end else begin
          good_d[n] = '0;
          if (bad_q[n] != UNLOCK_N) bad_d[n] = bad_q[n] + HYST_ONE;
          if (bad_d[n] == UNLOCK_N) lock_d[n] = 1'b0;
        end
      end
      if (int'(sel_i) < NUM_NODES) err_full = int'($signed(diff[sel_i]));
      if (err_full > ERR_MAX) err_full = ERR_MAX;
      if (err_full < ERR_MIN) err_full = ERR_MIN;
      err_d       = ERR_WIDTH'(err_full);
      err_valid_d = 1'b1;
    end
    // Dropping enable discards all lock history but leaves the last reported error.
    if (!enable_i) begin
      good_d      = '0;
      bad_d       = '0;
      lock_d      = '0;
      err_d       = err_q;
      err_valid_d = 1'b0;
    end
    all_locked_d = &lock_d;
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      snap_q       <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      lock_q       <= '0;
      all_locked_q <= 1'b0;
      err_q        <= '0;
      err_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      lock_q       <= lock_d;
      all_locked_q <= all_locked_d;
      err_q        <= err_d;
      err_valid_q  <= err_valid_d;
    end
  end

  assign lock_o       = lock_q;
  assign all_locked_o = all_locked_q;
  assign err_o        = err_q;
  assign err_valid_o  = err_valid_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_network_lock_monitor.sv
// Scoreboard bench for network_lock_monitor: directed windows with hand-computed results,
// reference period 20 cycles, 16-edge gate window.
module tb_network_lock_monitor;
  import network_lock_monitor_pkg::*;

  localparam int NN = 4;
  localparam int EW = 8;
  localparam int W  = 32 + EW + NN + 1;
  localparam int M_COPY = 0;
  localparam int M_LOW  = 1;
  localparam int M_PER  = 2;

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 enable_i = 1'b0;
  logic                 ref_i = 1'b1;
  logic [NN-1:0]        gen_i = '1;
  logic [1:0]           sel_i = '0;
  logic [NN-1:0]        lock_o;
  logic                 all_locked_o;
  logic signed [EW-1:0] err_o;
  logic                 err_valid_o;
  state_e               dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int tick   = -1;
  int mode[NN];
  int period[NN];
  logic rst_v, en_v;
  logic [1:0] sel_v;

  initial forever #5 clk = ~clk;

  network_lock_monitor #(
    .NUM_NODES(NN), .CNT_WIDTH(10), .WINDOW_EDGES(16), .TOL(1),
    .LOCK_WINDOWS(2), .UNLOCK_WINDOWS(2), .ERR_WIDTH(EW)
  ) dut (
    .fpga_clk_i   (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .ref_i        (ref_i),
    .gen_i        (gen_i),
    .sel_i        (sel_i),
    .lock_o       (lock_o),
    .all_locked_o (all_locked_o),
    .err_o        (err_o),
    .err_valid_o  (err_valid_o),
    .dbg_state_o  (dbg_state)
  );

  // Driver: one call advances one cycle and applies every input for that cycle.
  task automatic step();
    @(posedge clk);
    #1;
    tick     = tick + 1;
    reset_i  = rst_v;
    enable_i = en_v;
    sel_i    = sel_v;
    ref_i    = (tick % 20) < 10;
    for (int n = 0; n < NN; n++) begin
      case (mode[n])
        M_LOW:   gen_i[n] = 1'b0;
        M_PER:   gen_i[n] = (tick % period[n]) < (period[n] / 2);
        default: gen_i[n] = ref_i;
      endcase
    end
  endtask

  task automatic wait_tick(input int t);
    while (tick < t) step();
  endtask

  task automatic start_test(input logic [1:0] sel);
    sel_v = sel;
    en_v  = 1'b1;
    rst_v = 1'b1;
    tick  = -1;
    repeat (5) step();
    rst_v = 1'b0;
    step();
  endtask

  task automatic push_exp(input int t, input int err, input logic [NN-1:0] lock, input logic all);
    logic [31:0]   t_v;
    logic [EW-1:0] e_v;
    t_v = t;
    e_v = EW'(err);
    exp_q.push_back({t_v, e_v, lock, all});
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d (tick %0d)", name, got, exp, tick);
    end
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing %0d err_valid pulses, next required tick=%0d",
               name, exp_q.size(), exp_q[0][W-1 -: 32]);
    end
    exp_q.delete();
  endtask

  task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
  endtask

  // Monitor: every err_valid pulse consumes one expected record (tick, err, lock, all_locked).
  always @(negedge clk) begin
    if (err_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse tick=%0d err=%0d lock=%h", tick, err_o, lock_o);
      end else begin
        logic [W-1:0] e;
        logic [31:0]  t_v;
        e   = exp_q.pop_front();
        t_v = tick;
        if ({t_v, err_o, lock_o, all_locked_o} !== e) begin
          errors++;
          $display("FAIL window got tick=%0d err=%0d lock=%h all=%b required tick=%0d err=%0d lock=%h all=%b",
                   tick, err_o, lock_o, all_locked_o, e[W-1 -: 32], $signed(e[NN+EW:NN+1]),
                   e[NN:1], e[0]);
        end
      end
    end
  end

  initial begin
    rst_v = 1'b1;
    en_v  = 1'b0;
    sel_v = '0;
    for (int n = 0; n < NN; n++) begin
      mode[n]   = M_COPY;
      period[n] = 16;
    end

    // Reset with ref high at release; arming waits for the edge at tick 20.
    set_modes(M_COPY, M_COPY, M_COPY, M_COPY);
    start_test(2'd0);
    check("reset_lock", int'(lock_o), 0);
    check("reset_all_locked", int'(all_locked_o), 0);
    check("reset_err", int'(err_o), 0);
    check("reset_err_valid", int'(err_valid_o), 0);
    check("reset_state", int'(dbg_state), int'(ST_IDLE));
    wait_tick(19);
    check("arm_waits_for_edge", int'(dbg_state), int'(ST_ARM));
    wait_tick(21);
    check("count_after_edge", int'(dbg_state), int'(ST_COUNT));
    push_exp(342, 0, 4'h0, 1'b0);
    push_exp(662, 0, 4'hF, 1'b1);
    push_exp(982, 0, 4'hF, 1'b1);
    wait_tick(990);
    drain_check("all_copy");

    // Node 2 fast: 20 edges per window.
    set_modes(M_COPY, M_COPY, M_PER, M_COPY);
    period[2] = 16;
    start_test(2'd2);
    push_exp(342, 4, 4'h0, 1'b0);
    push_exp(662, 4, 4'hB, 1'b0);
    push_exp(982, 4, 4'hB, 1'b0);
    wait_tick(990);
    drain_check("node2_fast");

    // Lock everything, then starve node 1 from the start of window 3.
    set_modes(M_COPY, M_COPY, M_COPY, M_COPY);
    start_test(2'd1);
    push_exp(342, 0, 4'h0, 1'b0);
    push_exp(662, 0, 4'hF, 1'b1);
    push_exp(982, -16, 4'hF, 1'b1);
    push_exp(1302, -16, 4'hD, 1'b0);
    wait_tick(662);
    mode[1] = M_LOW;
    wait_tick(1310);
    drain_check("node1_unlock");

    // Node 0 at period 2: 160 edges, error clamps to +127.
    set_modes(M_PER, M_COPY, M_COPY, M_COPY);
    period[0] = 2;
    start_test(2'd0);
    push_exp(342, 127, 4'h0, 1'b0);
    push_exp(662, 127, 4'hE, 1'b0);
    wait_tick(670);
    drain_check("node0_saturate");

    // Enable dropped mid-window, then re-armed while ref is low.
    set_modes(M_COPY, M_COPY, M_COPY, M_PER);
    period[3] = 16;
    start_test(2'd3);
    push_exp(342, 4, 4'h0, 1'b0);
    push_exp(662, 4, 4'h7, 1'b0);
    wait_tick(762);
    check("lock_before_disable", int'(lock_o), 7);
    en_v = 1'b0;
    step();
    step();
    check("disable_state", int'(dbg_state), int'(ST_IDLE));
    check("disable_lock", int'(lock_o), 0);
    check("disable_all_locked", int'(all_locked_o), 0);
    check("disable_err_hold", int'(err_o), 4);
    check("disable_no_pulse", int'(err_valid_o), 0);
    wait_tick(1014);
    check("idle_err_hold", int'(err_o), 4);
    check("idle_state", int'(dbg_state), int'(ST_IDLE));
    en_v = 1'b1;
    push_exp(1342, 4, 4'h0, 1'b0);
    push_exp(1662, 4, 4'h7, 1'b0);
    wait_tick(1670);
    drain_check("reenable");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
